// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared state encoding and constants for the fetch stage.
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

endpackage

// File: rtl/inst_fetch_unit_fetch_out_reg.sv
// fetch_out_reg: single-entry valid/ready holding register for {pc, instr}, cleared by flush.
// FETCH_ALIGN_CHECK_EN adds a misalign flag that travels with the entry.
module fetch_out_reg #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] instr_i,
`ifdef FETCH_ALIGN_CHECK_EN
    input  logic              misalign_i,
    output logic              misalign_o,
`endif
    input  logic              ready_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] instr_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] instr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            valid_q <= !flush_i && (load_i || (valid_q && !ready_i));
            if (load_i && !flush_i) begin
                pc_q    <= pc_i;
                instr_q <= instr_i;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    // The flag is only ever set together with valid, so it clears on the same handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) misalign_q <= 1'b0;
        else         misalign_q <= !flush_i && (load_i ? misalign_i : misalign_q && !ready_i);
    end

    assign misalign_o = misalign_q;
`endif

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: issues one memory read per PC, captures the word and hands {pc, instr} to decode.
// FETCH_ALIGN_CHECK_EN replaces fetches of unaligned PCs with a flagged NOP (FetchMisalign port).
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              Clock,
    input  logic              NReset,
    input  logic [ADDR_W-1:0] PcAddress,
    output logic              PcStall,
    input  logic              Flush,
    output logic              ReqValid,
    input  logic              ReqReady,
    output logic [ADDR_W-1:0] ReqAddr,
    input  logic              RespValid,
    input  logic [DATA_W-1:0] RespData,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic              FetchMisalign,
`endif
    output logic              OutValid,
    input  logic              OutReady,
    output logic [ADDR_W-1:0] OutPc,
    output logic [DATA_W-1:0] OutInstr
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] saved_pc_q;
    logic              run_q;
    logic              can_issue, misalign, req_fire, mis_load, resp_take;

    // run_q keeps the request channel quiet until the first edge after reset.
    assign can_issue = run_q && state_q == FETCH_IDLE && !Flush && (!OutValid || OutReady);
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign  = |PcAddress[1:0];
`else
    assign misalign  = 1'b0;
`endif
    assign ReqValid  = can_issue && !misalign;
    assign ReqAddr   = PcAddress & ~ADDR_W'(3);
    assign req_fire  = ReqValid && ReqReady;
    assign mis_load  = can_issue && misalign;
    assign PcStall   = !(req_fire || mis_load);
    assign resp_take = state_q == FETCH_WAIT && RespValid && !Flush;

    always_comb
        state_d = state_q == FETCH_IDLE ? (req_fire ? FETCH_WAIT : FETCH_IDLE)
                : state_q == FETCH_WAIT ? (RespValid ? FETCH_IDLE : Flush ? FETCH_DROP : FETCH_WAIT)
                : (RespValid ? FETCH_IDLE : FETCH_DROP);

    always_ff @(posedge Clock or negedge NReset) begin
        if (!NReset) begin
            state_q    <= FETCH_IDLE;
            saved_pc_q <= RESET_PC;
            run_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (req_fire) saved_pc_q <= PcAddress;
        end
    end

    fetch_out_reg #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(RESET_PC)
    ) u_out_reg (
        .clk_i     (Clock),
        .rst_ni    (NReset),
        .flush_i   (Flush),
        .load_i    (resp_take || mis_load),
        .pc_i      (mis_load ? PcAddress : saved_pc_q),
        .instr_i   (mis_load ? DATA_W'(NOP_INSTR) : RespData),
`ifdef FETCH_ALIGN_CHECK_EN
        .misalign_i(mis_load),
        .misalign_o(FetchMisalign),
`endif
        .ready_i   (OutReady),
        .valid_o   (OutValid),
        .pc_o      (OutPc),
        .instr_o   (OutInstr)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: random PC/memory/decode/flush traffic checked against a behavioural fetch model.
module tb_inst_fetch_unit;

    logic        Clock = 1'b0;
    logic        NReset = 1'b0;
    logic [31:0] PcAddress = '0;
    logic        PcStall;
    logic        Flush = 1'b0;
    logic        ReqValid;
    logic        ReqReady = 1'b0;
    logic [31:0] ReqAddr;
    logic        RespValid = 1'b0;
    logic [31:0] RespData = '0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] OutPc;
    logic [31:0] OutInstr;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        FetchMisalign;
`endif

    inst_fetch_unit dut (
        .Clock        (Clock),
        .NReset       (NReset),
        .PcAddress    (PcAddress),
        .PcStall      (PcStall),
        .Flush        (Flush),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqAddr      (ReqAddr),
        .RespValid    (RespValid),
        .RespData     (RespData),
`ifdef FETCH_ALIGN_CHECK_EN
        .FetchMisalign(FetchMisalign),
`endif
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutPc        (OutPc),
        .OutInstr     (OutInstr)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int errors  = 0;

    // Model: memory with one outstanding read, decode-side single entry, and the PC register.
    logic        busy, stale, exp_valid, exp_mis;
    int          cnt;
    logic [31:0] busy_pc, pc, exp_pc, exp_instr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        busy = 0; stale = 0; cnt = 0; pc = 0;
        exp_valid = 0; exp_mis = 0; exp_pc = 0; exp_instr = 0;
    endtask

    task automatic step(input int flush_pct);
        logic        resp, mis, issue, exp_req;
        logic [31:0] target;
        @(posedge Clock); #1;
        resp      = busy && cnt == 0;
        RespValid = resp;
        RespData  = resp ? mem(busy_pc) : $urandom;
        ReqReady  = $urandom_range(0, 3) != 0;
        OutReady  = $urandom_range(0, 3) != 0;
        Flush     = $urandom_range(0, 99) < flush_pct;
        PcAddress = pc;
        @(negedge Clock);
`ifdef FETCH_ALIGN_CHECK_EN
        mis = pc[1:0] != 2'b00;
`else
        mis = 1'b0;
`endif
        issue   = !busy && !Flush && (!exp_valid || OutReady);
        exp_req = issue && !mis;
        chk("req_valid", ReqValid, exp_req);
        if (exp_req) chk("req_addr", ReqAddr, {pc[31:2], 2'b00});
        chk("pc_stall", PcStall, !(issue && (mis || ReqReady)));
        chk("out_valid", OutValid, exp_valid);
        if (exp_valid) begin
            chk("out_pc", OutPc, exp_pc);
            chk("out_instr", OutInstr, exp_instr);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign", FetchMisalign, exp_valid && exp_mis);
`endif
        if (Flush) begin
            exp_valid = 0; exp_mis = 0;
        end else if (resp && !stale) begin
            exp_valid = 1; exp_pc = busy_pc; exp_instr = mem(busy_pc); exp_mis = 0;
        end else if (issue && mis) begin
            exp_valid = 1; exp_pc = pc; exp_instr = 32'h0; exp_mis = 1;
        end else if (exp_valid && OutReady) begin
            exp_valid = 0; exp_mis = 0;
        end
        if (busy) begin
            if (resp) begin
                busy = 0; stale = 0;
            end else begin
                if (Flush) stale = 1;
                cnt--;
            end
        end else if (exp_req && ReqReady) begin
            busy = 1; busy_pc = pc; cnt = $urandom_range(0, 3);
        end
        target = ($urandom & 32'h3FC) | ($urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
        if (Flush) pc = target;
        else if ((exp_req && ReqReady) || (issue && mis)) pc = pc + 4;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, OutValid, 0);
        chk({tag, "_out_pc"}, OutPc, 0);
        chk({tag, "_out_instr"}, OutInstr, 0);
        chk({tag, "_req_valid"}, ReqValid, 0);
        chk({tag, "_pc_stall"}, PcStall, 1);
`ifdef FETCH_ALIGN_CHECK_EN
        chk({tag, "_misalign"}, FetchMisalign, 0);
`endif
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge Clock);
        #1 chk_reset_outputs("rst");
        @(negedge Clock) NReset = 1'b1;
        repeat (600) step(10);
        for (int i = 0; i < 50 && !busy; i++) step(0);
        chk("reach_wait", busy, 1);
        @(posedge Clock); #2;
        NReset = 1'b0;
        #1 chk_reset_outputs("async_rst");
        RespValid = 1'b1; RespData = 32'hDEADBEEF; ReqReady = 1'b0; Flush = 1'b0; PcAddress = '0;
        @(negedge Clock) NReset = 1'b1;
        @(posedge Clock); #1 RespValid = 1'b0;
        @(negedge Clock) chk("stray_resp", OutValid, 0);
        model_reset();
        repeat (600) step(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Takes the current PC, issues one word read to instruction memory over a valid/ready request channel, and captures the returned word.
- Presents {pc, instr} to decode through a valid/ready output register.
- Drives a stall signal back to next-PC selection so the PC holds while a fetch is outstanding or decode is backpressuring; accepts a flush for branch/jump redirects.

Parameters:
- ADDR_W, 32, PC/memory address width
- DATA_W, 32, instruction word width
- RESET_PC, 32'h0, PC value reported on outputs after reset (matches PC reset)

Ports:
- Clock  in  1  system clock, rising edge
- NReset  in  1  asynchronous active-low reset
- PcAddress  in  ADDR_W  current PC from PC register
- PcStall  out  1  1 = next-PC logic must feed PcAddress back unchanged
- Flush  in  1  redirect: discard in-flight and buffered fetch
- ReqValid  out  1  memory read request valid
- ReqReady  in  1  memory accepts request
- ReqAddr  out  ADDR_W  request address, {PcAddress[ADDR_W-1:2],2'b00}
- RespValid  in  1  memory returns data (exactly one per accepted request, ≥1 cycle after accept)
- RespData  in  DATA_W  instruction word
- OutValid  out  1  fetched instruction valid to decode
- OutReady  in  1  decode accepts
- OutPc  out  ADDR_W  PC of OutInstr
- OutInstr  out  DATA_W  instruction word

Behaviour:
- States: IDLE (may issue), WAIT (request accepted, awaiting response), DROP (flushed while awaiting; discard next response).
- Reset (async, NReset=0): state=IDLE; OutValid=0, OutPc=RESET_PC, OutInstr=0, ReqValid=0, internal saved-PC=RESET_PC. PcStall is combinational from state and is 1 after reset, because ReqValid=0.
- IDLE: ReqValid=1 when output register is empty, or will empty this cycle (OutValid&OutReady), and Flush=0.
- Request accepted (ReqValid&ReqReady): save PcAddress, go to WAIT.
- PcStall=0 only in the cycle a request is accepted; PC advances exactly once per accepted fetch. Otherwise PcStall=1.
- WAIT & RespValid & !Flush: load OutPc=saved-PC, OutInstr=RespData, OutValid=1, go to IDLE. Latency from request accept to OutValid is response latency + 1 cycle.
- WAIT & Flush & !RespValid: go to DROP.
- WAIT & Flush & RespValid: response discarded, go to IDLE.
- DROP & RespValid: discard, go to IDLE. Flush in DROP has no further effect.
- Output register: OutValid cleared on OutValid&OutReady unless reloaded in the same cycle. The single-entry register plus a single outstanding request guarantees no response arrives while the register is full.
- Flush (any state): OutValid cleared next edge. ReqValid forced 0 in that cycle. PcStall=1 in the flush cycle so the redirect target is loaded by next-PC logic. Flush has priority over OutReady and RespValid capture.
- RespValid in IDLE is a protocol error and is ignored.
- ReqValid, once asserted, holds with a stable ReqAddr until ReqReady, unless Flush drops it.
- Async reset mid-WAIT clears state; a late response after reset is ignored in IDLE.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- When defined: output port FetchMisalign (1 bit). If PcAddress[1:0]!=0 when a request would issue, no request is sent. Instead the output register loads OutPc=PcAddress, OutInstr=32'h0 (NOP), OutValid=1, and FetchMisalign=1 alongside it; PcStall=0 for that cycle. FetchMisalign resets to 0 and clears with OutValid.
- When undefined: port absent; low address bits are silently masked in ReqAddr.

Decomposition:
- Shared package holds: state encoding constants (FETCH_IDLE=2'd0, FETCH_WAIT=2'd1, FETCH_DROP=2'd2), NOP_INSTR=32'h0, default reset PC.
- One natural sub-module: fetch_out_reg, the single-entry valid/ready holding register with flush clear.

Test Plan:
- Reset then ReqReady=1, 1-cycle memory latency, OutReady=1, PC=0,4,8 -> OutPc 0,4,8 with OutInstr matching memory; one fetch every 2 cycles; PcStall low once per fetch.
- OutReady=0 with OutValid holding PC=4 -> no new ReqValid, PcStall=1, OutPc/OutInstr stable; OutReady=1 -> request for PC=8 issued that same cycle.
- Flush one cycle after request for PC=8 accepted, response 3 cycles later -> response dropped, OutValid stays 0, next request uses redirected PC=0x40.
- Flush in the same cycle as RespValid -> no OutValid, state IDLE next cycle.
- NReset pulsed low during WAIT -> all outputs at reset values immediately; stray RespValid ignored.
- With FETCH_ALIGN_CHECK_EN, PcAddress=0x6 -> no ReqValid, OutValid=1, FetchMisalign=1, OutInstr=0.
